order_ingress_arbiter: RTL and testbench
========================================

Name: order_ingress_arbiter

Overview:
- Merges NUM_PORTS independent order streams into the single order-entry port of the order book (slave_tdata/slave_tvalid).
- Each order word is {price[63:32], volume[31:0]}.
- Grants requesters fairly with round-robin and presents one registered order at a time, holding it until the book accepts it.
- Enforces a programmable quiet gap after each accepted order so the book's sorted insertion can settle, and drops zero-volume orders without forwarding them.

Parameters:
- NUM_PORTS, 4, number of upstream order sources (2..8).
- DATA_W, 64, order word width, {price[31:0], volume[31:0]}.
- GAP_CYCLES, 2, idle cycles inserted after each downstream handshake (0..15).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  NUM_PORTS*DATA_W  per-port order word; port i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  NUM_PORTS  per-port order valid.
- s_tready  out  NUM_PORTS  per-port accept; one-hot or zero.
- m_tdata  out  DATA_W  registered order to book slave_tdata.
- m_tvalid  out  1  to book slave_tvalid.
- m_tready  in  1  book ready; tie high if the book is always ready.
- grant_id  out  $clog2(NUM_PORTS)  source port of the order currently on m_tdata.
- busy  out  1  high in any state other than IDLE.
- fwd_cnt  out  CNT_W  orders forwarded to the book.
- drop_cnt  out  CNT_W  zero-volume orders discarded.

Behaviour:
Reset values (rst=1 at a clock edge):
- State=IDLE; m_tvalid=0; m_tdata=0; grant_id=0; s_tready=0.
- fwd_cnt=0; drop_cnt=0; gap counter=0.
- RR pointer last=NUM_PORTS-1, so port 0 has first priority.
- rst mid-transfer discards any held order. A source whose s_tready was high in the reset cycle is not considered accepted.

FSM states are IDLE, OFFER and GAP.

IDLE:
- sel = first i with s_tvalid[i]=1, searching (last+1) mod NUM_PORTS upward with wrap.
- If sel exists: s_tready[sel]=1 combinationally this cycle and all other bits 0. The order is consumed this cycle and last<=sel.
- If volume==0: drop_cnt++, stay in IDLE, m_tvalid stays 0.
- Else: m_tdata<=word, grant_id<=sel, m_tvalid<=1, go to OFFER. m_tvalid is high on the cycle after the upstream handshake (latency 1).
- If no s_tvalid: s_tready=0 and stay in IDLE.

OFFER:
- m_tvalid=1. m_tdata and grant_id are held stable until m_tready=1. s_tready=0.
- On handshake (m_tvalid & m_tready): fwd_cnt++ and m_tvalid<=0.
- Then, if GAP_CYCLES>0, load gap counter with GAP_CYCLES-1 and go to GAP; otherwise go to IDLE.

GAP:
- s_tready=0 and m_tvalid=0.
- When the counter is 0, go to IDLE; otherwise decrement.
- Exactly GAP_CYCLES cycles are spent in GAP.

Throughput and fairness:
- Best case is one order per 2+GAP_CYCLES cycles.
- A port that keeps tvalid high is served at least once every NUM_PORTS grants.
- Dropped orders advance the RR pointer like forwarded ones.

Counters and arithmetic:
- Counters saturate at all-ones and do not wrap.
- Price is not inspected; only volume==0 triggers a drop.

Upstream rules:
- Sources must hold s_tdata stable while s_tvalid=1 and s_tready=0.
- A source deasserting tvalid before its grant is legal. It simply is not selected.

Test Plan:
1. Single source, GAP_CYCLES=2: port0 sends {12304,27} with m_tready=1. Required: s_tready[0] in cycle t; m_tvalid and m_tdata={12304,27} in t+1; m_tvalid=0 in t+2..t+3; IDLE at t+4; fwd_cnt=1.
2. Round-robin: ports 0..3 all assert tvalid continuously with distinct prices 12000..12003. Required: grant_id sequence is 0,1,2,3,0; each port's s_tready is high exactly once per 4 grants.
3. Backpressure: m_tready=0 for 5 cycles after m_tvalid rises with {12702,71} from port 2. Required: m_tdata and grant_id=2 held stable; all s_tready=0; exactly one handshake once m_tready=1; fwd_cnt increments by exactly 1.
4. Zero-volume drop: port1 sends {12500,0}, then port1 sends {12500,15}. Required: the first order is consumed without m_tvalid and drop_cnt=1; the second is forwarded; grant goes to port2 if it is also valid.
5. Reset mid-OFFER: assert rst while m_tvalid=1. Required: the next cycle shows m_tvalid=0, busy=0, counters=0, and the port0-first priority is restored.
6. Saturation: with CNT_W=4, forward 20 orders. Required: fwd_cnt stops at 15.

Source files
------------

// File: rtl/order_ingress_if.sv
// Order ingress bus: per-port upstream order streams
// plus the single downstream order-entry channel.
interface order_ingress_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
);
  logic [NUM_PORTS*DATA_W-1:0] s_tdata;
  logic [NUM_PORTS-1:0]        s_tvalid;
  logic [NUM_PORTS-1:0]        s_tready;
  logic [DATA_W-1:0]           m_tdata;
  logic                        m_tvalid;
  logic                        m_tready;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/order_ingress_arbiter.sv
// Round-robin merge of order streams into the book,
// with a quiet gap after each order and zero-volume drop.
module order_ingress_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 64,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  order_ingress_if.slave               bus,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             fwd_cnt,
  output logic [CNT_W-1:0]             drop_cnt
);
  localparam int IDW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [3:0]         gap_q, gap_d;
  logic [CNT_W-1:0]   fwd_q, fwd_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [IDW-1:0]     sel;
  logic [IDW-1:0]     idx;
  logic               found;
  logic [DATA_W-1:0]  word;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // first valid port after last grant, with wrap
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = IDW'((int'(last_q) + k) % NUM_PORTS);
      if (!found && bus.s_tvalid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    word = bus.s_tdata[int'(sel)*DATA_W +: DATA_W];
  end

  // next state, upstream accept and counter updates
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gid_d        = gid_q;
    data_d       = data_q;
    gap_d        = gap_q;
    fwd_d        = fwd_q;
    drop_d       = drop_q;
    bus.s_tready = '0;
    unique case (state_q)
      IDLE: begin
        if (found && !rst) begin
          bus.s_tready[sel] = 1'b1;
          last_d = sel;
          if (word[31:0] == '0) begin
            drop_d = sat_inc(drop_q);
          end else begin
            data_d  = word;
            gid_d   = sel;
            state_d = OFFER;
          end
        end
      end
      OFFER: begin
        if (bus.m_tready) begin
          fwd_d = sat_inc(fwd_q);
          if (GAP_CYCLES > 0) begin
            gap_d   = 4'(GAP_CYCLES - 1);
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NUM_PORTS - 1);
      gid_q   <= '0;
      data_q  <= '0;
      gap_q   <= '0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.m_tdata  = data_q;
  assign bus.m_tvalid = (state_q == OFFER);
  assign grant_id     = gid_q;
  assign busy         = (state_q != IDLE);
  assign fwd_cnt      = fwd_q;
  assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_order_ingress_arbiter.sv
// Bench for order_ingress_arbiter: directed scenarios
// and random traffic against a transaction model.
module tb_order_ingress_arbiter;
  localparam int NP  = 4;
  localparam int DW  = 64;
  localparam int GAP = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    grant_id;
  logic          busy;
  logic [CW-1:0] fwd_cnt;
  logic [CW-1:0] drop_cnt;

  order_ingress_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  order_ingress_arbiter #(
    .NUM_PORTS(NP), .DATA_W(DW),
    .GAP_CYCLES(GAP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant_id(grant_id), .busy(busy),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit          src_v [NP];
  logic [63:0] src_w [NP];

  int          m_last;
  bit          m_pend;
  logic [63:0] m_word;
  int          m_gid;
  int          m_gap;
  int          m_fwd;
  int          m_drop;
  int          n_hs;
  int          grants[$];

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (m_last + k) % NP;
      if (src_v[p]) return p;
    end
    return -1;
  endfunction

  function automatic int sat(int v);
    return (v < SAT) ? v + 1 : SAT;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.s_tvalid[p]         = src_v[p];
      bus.s_tdata[p*DW +: DW] = src_w[p];
    end
  endtask

  task automatic step();
    bit         idle;
    int         p;
    logic [3:0] er;
    drive();
    @(negedge clk);
    idle = !m_pend && (m_gap == 0);
    p    = (idle && !rst) ? pick() : -1;
    er   = (p >= 0) ? 4'(1 << p) : 4'd0;
    chk("s_tready", bus.s_tready, er);
    if (!rst) begin
      chk("m_tvalid", bus.m_tvalid, m_pend);
      chk("busy", busy, !idle);
      chk("fwd_cnt", fwd_cnt, m_fwd);
      chk("drop_cnt", drop_cnt, m_drop);
      if (m_pend) begin
        chk("m_tdata", bus.m_tdata, m_word);
        chk("grant_id", grant_id, m_gid);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        n_hs++;
        grants.push_back(int'(grant_id));
      end
    end
    if (rst) begin
      m_last = NP - 1;
      m_pend = 0;
      m_gap  = 0;
      m_fwd  = 0;
      m_drop = 0;
    end else if (p >= 0) begin
      m_last   = p;
      src_v[p] = 0;
      if (src_w[p][31:0] == 0) begin
        m_drop = sat(m_drop);
      end else begin
        m_pend = 1;
        m_word = src_w[p];
        m_gid  = p;
      end
    end else if (m_pend) begin
      if (bus.m_tready) begin
        m_fwd  = sat(m_fwd);
        m_pend = 0;
        m_gap  = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clr_src();
    for (int p = 0; p < NP; p++) begin
      src_v[p] = 0;
      src_w[p] = '0;
    end
  endtask

  task automatic rand_src();
    for (int p = 0; p < NP; p++) begin
      if (!src_v[p]) begin
        if ($urandom_range(2) == 0) begin
          src_v[p] = 1;
          src_w[p][63:32] = $urandom();
          src_w[p][31:0]  = ($urandom_range(4) == 0) ?
                            32'd0 :
                            32'($urandom_range(999) + 1);
        end
      end else if ($urandom_range(15) == 0) begin
        src_v[p] = 0;
      end
    end
    bus.m_tready = ($urandom_range(3) != 0);
  endtask

  int exp2[5] = '{0, 1, 2, 3, 0};
  int f0;

  initial begin
    rst = 1'b1;
    bus.m_tready = 1'b0;
    clr_src();
    m_last = NP - 1;
    m_pend = 0;
    m_gap  = 0;
    m_fwd  = 0;
    m_drop = 0;
    n_hs   = 0;
    step();
    step();
    rst = 1'b0;

    // 1: single order, gap timing
    src_v[0] = 1;
    src_w[0] = {32'd12304, 32'd27};
    bus.m_tready = 1'b1;
    repeat (6) step();
    chk("t1_fwd", fwd_cnt, 1);

    // 2: round-robin with all ports valid
    do_reset();
    grants.delete();
    for (int c = 0; c < 40 && grants.size() < 5; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!src_v[p]) begin
          src_v[p] = 1;
          src_w[p] = {32'(12000 + p), 32'(100 + p)};
        end
      end
      step();
    end
    chk("t2_n", grants.size() >= 5, 1);
    if (grants.size() >= 5)
      for (int i = 0; i < 5; i++)
        chk($sformatf("t2_g%0d", i), grants[i], exp2[i]);

    // 3: backpressure on a held order
    clr_src();
    do_reset();
    f0 = int'(fwd_cnt);
    src_v[2] = 1;
    src_w[2] = {32'd12702, 32'd71};
    bus.m_tready = 1'b0;
    step();
    repeat (5) step();
    chk("t3_gid", grant_id, 2);
    bus.m_tready = 1'b1;
    repeat (4) step();
    chk("t3_fwd", fwd_cnt, f0 + 1);

    // 4: zero-volume drop, then forward
    clr_src();
    do_reset();
    grants.delete();
    src_v[1] = 1;
    src_w[1] = {32'd12500, 32'd0};
    repeat (2) step();
    chk("t4_drop", drop_cnt, 1);
    chk("t4_nohs", grants.size(), 0);
    src_v[1] = 1;
    src_w[1] = {32'd12500, 32'd15};
    src_v[2] = 1;
    src_w[2] = {32'd12600, 32'd9};
    repeat (10) step();
    chk("t4_n", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("t4_g0", grants[0], 2);
      chk("t4_g1", grants[1], 1);
    end

    // 5: reset while offering
    clr_src();
    src_v[1] = 1;
    src_w[1] = {32'd12600, 32'd5};
    bus.m_tready = 1'b0;
    repeat (2) step();
    chk("t5_tv", bus.m_tvalid, 1);
    do_reset();
    src_v[0] = 1;
    src_w[0] = {32'd1, 32'd2};
    src_v[3] = 1;
    src_w[3] = {32'd3, 32'd4};
    step();
    chk("t5_gid", grant_id, 0);
    bus.m_tready = 1'b1;
    repeat (8) step();

    // 6: forward counter saturation
    clr_src();
    do_reset();
    n_hs = 0;
    for (int c = 0; c < 200 && n_hs < 20; c++) begin
      if (!src_v[0]) begin
        src_v[0] = 1;
        src_w[0] = {$urandom(), 32'(c + 1)};
      end
      step();
    end
    chk("t6_hs", n_hs >= 20, 1);
    chk("t6_fwd", fwd_cnt, SAT);

    // random traffic with a mid-run reset
    clr_src();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_src();
      if (c == 1500) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
